// File: rtl/alu_decode_stage_pkg.sv
// Shared definitions for the RV32I decode stage and the ALU it feeds.
// The ALU imports the same aluc encoding, so changing it here changes both sides.
package alu_decode_stage_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001
    } aluc_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [1:0] SRC1_RS1  = 2'd0;
    localparam logic [1:0] SRC1_PC   = 2'd1;
    localparam logic [1:0] SRC1_ZERO = 2'd2;

    typedef struct packed {
        aluc_e       aluc;
        logic [1:0]  src1_sel;
        logic        src2_imm;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  funct3;
        logic        reg_we;
        logic        is_load;
        logic        is_store;
        logic        is_branch;
        logic        is_jump;
        logic        illegal;
    } dec_t;

    // alt selects the funct7=0100000 variant (SUB / SRA)
    function automatic aluc_e alu_from_funct3(input logic [2:0] f3, input logic alt);
        aluc_e op;
        case (f3)
            3'b000:  op = alt ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/rv32i_decoder.sv
// Purely combinational RV32I decoder: one instruction word in, one decode bundle out.
// Illegal encodings collapse to a harmless ADD with all side-effect flags cleared.
module rv32i_decoder
    import alu_decode_stage_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;
    logic [31:0] imm_shamt;
    logic        illegal;
    dec_t        d;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7    = instr[31:25];
    assign imm_i     = {{20{instr[31]}}, instr[31:20]};
    assign imm_s     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b     = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u     = {instr[31:12], 12'b0};
    assign imm_j     = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
    // shift-immediates hand the ALU the bare shift amount, not the funct7 bits
    assign imm_shamt = {27'b0, instr[24:20]};

    always_comb begin
        d          = '0;
        d.aluc     = ALU_ADD;
        d.src1_sel = SRC1_RS1;
        d.rs1      = instr[19:15];
        d.rs2      = instr[24:20];
        d.rd       = instr[11:7];
        d.funct3   = funct3;
        illegal    = 1'b0;

        case (opcode)
            OPC_OP: begin
                d.reg_we = 1'b1;
                if (funct7 == F7_BASE)
                    d.aluc = alu_from_funct3(funct3, 1'b0);
                else if (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101))
                    d.aluc = alu_from_funct3(funct3, 1'b1);
                else
                    illegal = 1'b1;
            end
            OPC_OP_IMM: begin
                d.reg_we   = 1'b1;
                d.src2_imm = 1'b1;
                d.imm      = imm_i;
                case (funct3)
                    3'b001: begin
                        d.imm = imm_shamt;
                        if (funct7 == F7_BASE) d.aluc = ALU_SLL;
                        else                   illegal = 1'b1;
                    end
                    3'b101: begin
                        d.imm = imm_shamt;
                        if (funct7 == F7_BASE)     d.aluc = ALU_SRL;
                        else if (funct7 == F7_ALT) d.aluc = ALU_SRA;
                        else                       illegal = 1'b1;
                    end
                    default: d.aluc = alu_from_funct3(funct3, 1'b0);
                endcase
            end
            OPC_LOAD: begin
                d.src2_imm = 1'b1;
                d.imm      = imm_i;
                d.reg_we   = 1'b1;
                d.is_load  = 1'b1;
            end
            OPC_STORE: begin
                d.src2_imm = 1'b1;
                d.imm      = imm_s;
                d.is_store = 1'b1;
            end
            OPC_BRANCH: begin
                d.imm       = imm_b;
                d.is_branch = 1'b1;
                case (funct3[2:1])
                    2'b00:   d.aluc = ALU_SUB;
                    2'b10:   d.aluc = ALU_SLT;
                    2'b11:   d.aluc = ALU_SLTU;
                    default: illegal = 1'b1;
                endcase
            end
            OPC_JAL: begin
                d.src1_sel = SRC1_PC;
                d.src2_imm = 1'b1;
                d.imm      = imm_j;
                d.reg_we   = 1'b1;
                d.is_jump  = 1'b1;
            end
            OPC_JALR: begin
                d.src2_imm = 1'b1;
                d.imm      = imm_i;
                d.reg_we   = 1'b1;
                d.is_jump  = 1'b1;
                if (funct3 != 3'b000) illegal = 1'b1;
            end
            OPC_LUI: begin
                d.src1_sel = SRC1_ZERO;
                d.src2_imm = 1'b1;
                d.imm      = imm_u;
                d.reg_we   = 1'b1;
            end
            OPC_AUIPC: begin
                d.src1_sel = SRC1_PC;
                d.src2_imm = 1'b1;
                d.imm      = imm_u;
                d.reg_we   = 1'b1;
            end
            default: illegal = 1'b1;
        endcase

        if (d.rd == 5'd0) d.reg_we = 1'b0;

        if (illegal) begin
            d.aluc      = ALU_ADD;
            d.src1_sel  = SRC1_RS1;
            d.src2_imm  = 1'b0;
            d.imm       = '0;
            d.reg_we    = 1'b0;
            d.is_load   = 1'b0;
            d.is_store  = 1'b0;
            d.is_branch = 1'b0;
            d.is_jump   = 1'b0;
        end
        d.illegal = illegal;
    end

    assign dec = d;

endmodule

// File: rtl/alu_decode_stage.sv
// Registered decode stage between fetch and execute with valid/ready on both sides.
// A single entry register; drain and refill happen in the same cycle, so no bubbles.
module alu_decode_stage
    import alu_decode_stage_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      out_aluc,
    output logic [1:0]      out_src1_sel,
    output logic            out_src2_imm,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [2:0]      out_funct3,
    output logic            out_reg_we,
    output logic            out_is_load,
    output logic            out_is_store,
    output logic            out_is_branch,
    output logic            out_is_jump,
    output logic [XLEN-1:0] out_pc,
    output logic            out_illegal
);

    dec_t dec;
    logic capture;

    rv32i_decoder u_decoder (
        .instr (in_instr[31:0]),
        .dec   (dec)
    );

    assign in_ready = !out_valid || out_ready;
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // payload only moves on capture; a flush just invalidates the held entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_aluc      <= ALU_ADD;
            out_src1_sel  <= SRC1_RS1;
            out_src2_imm  <= 1'b0;
            out_imm       <= '0;
            out_rs1       <= '0;
            out_rs2       <= '0;
            out_rd        <= '0;
            out_funct3    <= '0;
            out_reg_we    <= 1'b0;
            out_is_load   <= 1'b0;
            out_is_store  <= 1'b0;
            out_is_branch <= 1'b0;
            out_is_jump   <= 1'b0;
            out_pc        <= '0;
            out_illegal   <= 1'b0;
        end else if (capture && !flush) begin
            out_aluc      <= dec.aluc;
            out_src1_sel  <= dec.src1_sel;
            out_src2_imm  <= dec.src2_imm;
            out_imm       <= XLEN'($signed(dec.imm));
            out_rs1       <= dec.rs1;
            out_rs2       <= dec.rs2;
            out_rd        <= dec.rd;
            out_funct3    <= dec.funct3;
            out_reg_we    <= dec.reg_we;
            out_is_load   <= dec.is_load;
            out_is_store  <= dec.is_store;
            out_is_branch <= dec.is_branch;
            out_is_jump   <= dec.is_jump;
            out_pc        <= in_pc;
            out_illegal   <= dec.illegal;
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed bench for alu_decode_stage: decode vectors, backpressure, flush and async reset.
module tb_alu_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_aluc;
    logic [1:0]  out_src1_sel;
    logic        out_src2_imm;
    logic [31:0] out_imm;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [4:0]  out_rd;
    logic [2:0]  out_funct3;
    logic        out_reg_we;
    logic        out_is_load;
    logic        out_is_store;
    logic        out_is_branch;
    logic        out_is_jump;
    logic [31:0] out_pc;
    logic        out_illegal;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    alu_decode_stage #(.XLEN(32)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_instr      (in_instr),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_aluc      (out_aluc),
        .out_src1_sel  (out_src1_sel),
        .out_src2_imm  (out_src2_imm),
        .out_imm       (out_imm),
        .out_rs1       (out_rs1),
        .out_rs2       (out_rs2),
        .out_rd        (out_rd),
        .out_funct3    (out_funct3),
        .out_reg_we    (out_reg_we),
        .out_is_load   (out_is_load),
        .out_is_store  (out_is_store),
        .out_is_branch (out_is_branch),
        .out_is_jump   (out_is_jump),
        .out_pc        (out_pc),
        .out_illegal   (out_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // drive one instruction, let it be captured, sample 1 ns after the edge
    task automatic send(input logic [31:0] instr, input logic [31:0] pc);
        in_valid = 1'b1;
        in_instr = instr;
        in_pc    = pc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_instr  = '0;
        in_pc     = '0;
        out_ready = 1'b1;
        #12;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_aluc", 32'(out_aluc), 32'd0);
        chk("rst_imm", out_imm, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // ADD x3,x1,x2
        send(32'h002081B3, 32'h0000_0040);
        chk("add_valid", 32'(out_valid), 32'd1);
        chk("add_aluc", 32'(out_aluc), 32'h0);
        chk("add_rs1", 32'(out_rs1), 32'd1);
        chk("add_rs2", 32'(out_rs2), 32'd2);
        chk("add_rd", 32'(out_rd), 32'd3);
        chk("add_src2imm", 32'(out_src2_imm), 32'd0);
        chk("add_regwe", 32'(out_reg_we), 32'd1);
        chk("add_illegal", 32'(out_illegal), 32'd0);
        chk("add_pc", out_pc, 32'h0000_0040);

        send(32'h402081B3, 32'h0000_0044);
        chk("sub_aluc", 32'(out_aluc), 32'h1);

        // SRAI x5,x6,3
        send(32'h40335293, 32'h0000_0048);
        chk("srai_aluc", 32'(out_aluc), 32'h9);
        chk("srai_imm", out_imm, 32'd3);
        chk("srai_src2imm", 32'(out_src2_imm), 32'd1);

        // BLT x1,x2,-8
        send(32'hFE20CCE3, 32'h0000_004C);
        chk("blt_aluc", 32'(out_aluc), 32'h5);
        chk("blt_imm", out_imm, 32'hFFFF_FFF8);
        chk("blt_branch", 32'(out_is_branch), 32'd1);
        chk("blt_regwe", 32'(out_reg_we), 32'd0);
        chk("blt_src2imm", 32'(out_src2_imm), 32'd0);

        // LUI x7,0x12345
        send(32'h123453B7, 32'h0000_0050);
        chk("lui_src1", 32'(out_src1_sel), 32'd2);
        chk("lui_imm", out_imm, 32'h1234_5000);
        chk("lui_rd", 32'(out_rd), 32'd7);

        // JAL x1,+8
        send(32'h008000EF, 32'h0000_0054);
        chk("jal_src1", 32'(out_src1_sel), 32'd1);
        chk("jal_imm", out_imm, 32'd8);
        chk("jal_jump", 32'(out_is_jump), 32'd1);
        chk("jal_regwe", 32'(out_reg_we), 32'd1);

        // ADDI x0,x0,0: rd==0 suppresses the write
        send(32'h00000013, 32'h0000_0058);
        chk("nop_regwe", 32'(out_reg_we), 32'd0);
        chk("nop_illegal", 32'(out_illegal), 32'd0);

        send(32'hFFFFFFFF, 32'h0000_005C);
        chk("ones_valid", 32'(out_valid), 32'd1);
        chk("ones_illegal", 32'(out_illegal), 32'd1);
        chk("ones_regwe", 32'(out_reg_we), 32'd0);
        chk("ones_aluc", 32'(out_aluc), 32'h0);

        // OP with funct7=0000001
        send(32'h022081B3, 32'h0000_0060);
        chk("f7_illegal", 32'(out_illegal), 32'd1);
        chk("f7_regwe", 32'(out_reg_we), 32'd0);
        chk("f7_aluc", 32'(out_aluc), 32'h0);
        chk("f7_valid", 32'(out_valid), 32'd1);

        // SLLI with funct7=0100000 and BRANCH funct3=010 are both undecodable
        send(32'h40309293, 32'h0000_0064);
        chk("slli_alt_illegal", 32'(out_illegal), 32'd1);
        send(32'h0020A063, 32'h0000_0068);
        chk("br010_illegal", 32'(out_illegal), 32'd1);
        chk("br010_branch", 32'(out_is_branch), 32'd0);

        // backpressure: entry A held for 3 cycles while B waits
        send(32'h002081B3, 32'h0000_0100);
        out_ready = 1'b0;
        in_instr  = 32'h00408213;
        in_pc     = 32'h0000_0104;
        exp_q.push_back(32'h0000_0104);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_pc", out_pc, 32'h0000_0100);
            chk("bp_hold_rd", 32'(out_rd), 32'd3);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                in_instr = 32'h00408213 + (32'(k) << 7);
                in_pc    = 32'h0000_0104 + 32'(4 * k);
                exp_q.push_back(in_pc);
            end
            @(posedge clk);
            #1;
            chk("stream_valid", 32'(out_valid), 32'd1);
            chk("stream_pc", out_pc, exp_q.pop_front());
        end
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_valid", 32'(out_valid), 32'd0);

        // flush with both a held entry and a new input pending
        send(32'h002081B3, 32'h0000_0200);
        chk("pre_flush_valid", 32'(out_valid), 32'd1);
        flush    = 1'b1;
        in_instr = 32'h402081B3;
        in_pc    = 32'h0000_0204;
        @(posedge clk);
        #1;
        chk("flush_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;

        // async reset in the middle of a cycle with a valid entry held
        send(32'h123453B7, 32'h0000_0300);
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_pc", out_pc, 32'd0);
        chk("arst_imm", out_imm, 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
